sb_mux_cfg: RTL and testbench
=============================

SB_MUX_CFG -- requirements
Module: sb_mux_cfg

Interface
REQ-001 SHALL have parameter W, default 8, tracks per side (W >= 2).
REQ-002 SHALL have parameter CW, default 8, config word width; NBITS = 12*W, NWORDS = ceil(NBITS/CW), NWORDS >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_n, in_e, in_s, in_w  input  W each  track inputs from north, east, south and west.
REQ-006 SHALL have ports out_n, out_e, out_s, out_w  output  W each  track outputs to north, east, south and west.
REQ-007 SHALL have ports cfg_valid input 1, cfg_ready output 1, cfg_data input CW, cfg_last input 1  config word stream.
REQ-008 SHALL have ports cfg_clear input 1  error acknowledge; cfg_done output 1  commit pulse; cfg_err output 1  load error; cfg_busy output 1  load in progress.

Function
REQ-009 SHALL index outputs as o = side*W + i, with sides N=0, E=1, S=2, W=3; the active config bits [3o +: 3] are {reg, sel[1:0]}.
REQ-010 SHALL decode sel for an output on side d, track i, as: 00 = drive 0; 01 = input on side (d+1)%4, track i; 10 = input on side (d+2)%4, track i; 11 = input on side (d+3)%4, track i.
REQ-011 SHALL drive the output combinationally from the mux when reg=0, and from a flop that samples the mux every clk when reg=1.
REQ-012 SHALL hold separate shadow (NBITS) and active (NBITS) config registers; the datapath uses only active.
REQ-013 SHALL accept a word on the edge where cfg_valid & cfg_ready; word k is written to shadow[k*CW +: CW]; bits at or above NBITS in the final word are discarded.
REQ-014 SHALL implement FSM IDLE, LOAD, COMMIT, ERROR; cfg_ready=1 in IDLE and LOAD and 0 in COMMIT and ERROR.
REQ-015 IDLE: accepted word with cfg_last=0 -> LOAD with count=1; accepted word with cfg_last=1 -> ERROR.
REQ-016 LOAD: accepted word k < NWORDS-1 with cfg_last=1 -> ERROR; accepted word k = NWORDS-1 with cfg_last=1 -> COMMIT; accepted word k = NWORDS-1 with cfg_last=0 -> ERROR; otherwise count += 1.
REQ-017 COMMIT: lasts one cycle; active <= shadow on the exit edge; cfg_done=1 for exactly that cycle; next state IDLE.
REQ-018 ERROR: cfg_err=1 held; active unchanged; shadow contents are don't-care; cfg_clear=1 -> IDLE with count=0; cfg_clear in any other state has no effect.
REQ-019 cfg_busy SHALL be 1 in any state other than IDLE.
REQ-020 New active config SHALL take effect on the COMMIT exit edge: combinational outputs change after that edge, and registered outputs change one edge later.
REQ-021 Registered-output flops SHALL keep sampling while loading; only active change alters routing.

Reset
REQ-022 rst SHALL immediately set: state IDLE, count 0, active 0 (all outputs drive 0, reg=0), output flops 0, cfg_done 0, cfg_err 0; shadow SHALL reset to 0.
REQ-023 rst asserted mid-load or in ERROR SHALL abandon the load; the next full stream after rst release SHALL load normally.

Structure
REQ-024 Package sb_pkg SHALL hold the side enum, the sel encoding constants, the FSM state enum, and BITS_PER_OUT=3.
REQ-025 Sub-module sb_out_mux SHALL implement one output (4:1 mux with a 0 leg, plus an optional flop), instantiated 4*W times via generate.

Verification
REQ-026 rst=1 with random inputs -> all out_* = 0, cfg_ready=1, cfg_err=0, cfg_busy=0.
REQ-027 With W=8, CW=8 (NWORDS=12), stream 12 words setting out_n[0] sel=10, reg=0, with last on word 12, and drive in_s[0]=1 -> cfg_done pulses 1 cycle after word 12, then out_n[0]=1 combinationally; all other outputs remain 0.
REQ-028 Commit out_e[3] with sel=10, reg=1, then toggle in_w[3] 0->1 -> out_e[3] rises one clk later.
REQ-029 Assert cfg_last on word 5 -> cfg_err=1, cfg_ready=0, routing unchanged; pulse cfg_clear -> IDLE; a full 12-word reload then commits.
REQ-030 Send word 12 without cfg_last -> ERROR; hold cfg_valid=1 during COMMIT -> no word accepted because cfg_ready=0.
REQ-031 Assert rst after word 6 of a reload over a committed config -> all outputs 0 and state IDLE; a fresh 12-word load then commits correctly.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the switch-box mux with streamed configuration.
package sb_pkg;

  typedef enum logic [1:0] {
    SIDE_N = 2'd0,
    SIDE_E = 2'd1,
    SIDE_S = 2'd2,
    SIDE_W = 2'd3
  } side_e;

  localparam int NUM_SIDES    = 4;
  localparam int BITS_PER_OUT = 3;

  // sel field: which side feeds the output, counted clockwise from its own side
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_CW1  = 2'b01;
  localparam logic [1:0] SEL_OPP  = 2'b10;
  localparam logic [1:0] SEL_CW3  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERROR  = 2'd3
  } cfg_state_e;

  // Source side for an output on side d given its sel value
  function automatic int src_side(input int d, input int sel);
    return (d + sel) % NUM_SIDES;
  endfunction

endpackage

// File: rtl/sb_out_mux.sv
// One switch-box output: 4:1 mux with a constant-zero leg and an optional output flop.
module sb_out_mux
  import sb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITS_PER_OUT-1:0] cfg,   // {reg, sel[1:0]}
  input  logic [NUM_SIDES-1:1]    src,   // src[k] = same track on side (d+k)%4
  output logic                    out
);

  logic mux;
  logic q;

  // Source select
  always_comb begin
    mux = 1'b0;
    case (cfg[1:0])
      SEL_ZERO: mux = 1'b0;
      SEL_CW1:  mux = src[1];
      SEL_OPP:  mux = src[2];
      SEL_CW3:  mux = src[3];
      default:  mux = 1'b0;
    endcase
  end

  // Flop samples the mux every cycle regardless of reg, so switching to
  // registered mode shows a value that is at most one cycle old
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= mux;
  end

  assign out = cfg[2] ? q : mux;

endmodule

// File: rtl/sb_mux_cfg.sv
// Switch box with W tracks per side, configured by a word stream into a shadow
// register that is committed atomically into the active register.
module sb_mux_cfg
  import sb_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_n,
  input  logic [W-1:0]  in_e,
  input  logic [W-1:0]  in_s,
  input  logic [W-1:0]  in_w,
  output logic [W-1:0]  out_n,
  output logic [W-1:0]  out_e,
  output logic [W-1:0]  out_s,
  output logic [W-1:0]  out_w,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_last,
  input  logic          cfg_clear,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic          cfg_busy
);

  localparam int NOUT   = NUM_SIDES * W;
  localparam int NBITS  = NOUT * BITS_PER_OUT;
  localparam int NWORDS = (NBITS + CW - 1) / CW;
  localparam int CNTW   = $clog2(NWORDS);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NWORDS - 1);

  cfg_state_e       state, state_nxt;
  logic [CNTW-1:0]  count, count_nxt;
  logic [NBITS-1:0] shadow, active;
  logic [NOUT-1:0]  in_all, out_all;
  logic             accept;

  assign accept = cfg_valid & cfg_ready;

  // State and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Stream protocol: exactly NWORDS words with last only on the final one
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    cfg_err   = 1'b0;
    cfg_busy  = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (accept) begin
          state_nxt = cfg_last ? ST_ERROR : ST_LOAD;
          count_nxt = cfg_last ? '0 : CNTW'(1);
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (accept) begin
          if (count == LAST_IDX) begin
            state_nxt = cfg_last ? ST_COMMIT : ST_ERROR;
            count_nxt = '0;
          end else if (cfg_last) begin
            state_nxt = ST_ERROR;
            count_nxt = '0;
          end else begin
            count_nxt = count + CNTW'(1);
          end
        end
      end
      ST_COMMIT: begin
        cfg_done  = 1'b1;
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
      ST_ERROR: begin
        cfg_err = 1'b1;
        if (cfg_clear) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Shadow capture; bits past NBITS in the final word have no home and drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (accept) begin
      for (int b = 0; b < NBITS; b++)
        if (b / CW == int'(count)) shadow[b] <= cfg_data[b % CW];
    end
  end

  // Active config only moves on the COMMIT exit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    active <= '0;
    else if (state == ST_COMMIT) active <= shadow;
  end

  assign in_all = {in_w, in_s, in_e, in_n};

  for (genvar d = 0; d < NUM_SIDES; d++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_trk
      localparam int O = d * W + i;
      sb_out_mux u_mux (
        .clk (clk),
        .rst (rst),
        .cfg (active[O*BITS_PER_OUT +: BITS_PER_OUT]),
        .src ({in_all[src_side(d, 3)*W + i],
               in_all[src_side(d, 2)*W + i],
               in_all[src_side(d, 1)*W + i]}),
        .out (out_all[O])
      );
    end
  end

  assign out_n = out_all[int'(SIDE_N)*W +: W];
  assign out_e = out_all[int'(SIDE_E)*W +: W];
  assign out_s = out_all[int'(SIDE_S)*W +: W];
  assign out_w = out_all[int'(SIDE_W)*W +: W];

endmodule

// File: tb/tb_sb_mux_cfg.sv
// Randomized bench for sb_mux_cfg against a word-count based reference model.
module tb_sb_mux_cfg;

  localparam int W      = 8;
  localparam int CW     = 8;
  localparam int NO     = 4 * W;
  localparam int NBITS  = 3 * NO;
  localparam int NWORDS = (NBITS + CW - 1) / CW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] in_n = '0, in_e = '0, in_s = '0, in_w = '0;
  logic [W-1:0] out_n, out_e, out_s, out_w;
  logic cfg_valid = 1'b0, cfg_last = 1'b0, cfg_clear = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_ready, cfg_done, cfg_err, cfg_busy;

  int checks = 0;
  int failures = 0;
  bit rnd_in = 1'b1;

  // reference model state
  logic [NBITS-1:0] m_shadow, m_active;
  logic [NO-1:0]    m_q;
  bit               m_err, m_pend;
  int               m_n;

  sb_mux_cfg #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
    .out_n(out_n), .out_e(out_e), .out_s(out_s), .out_w(out_w),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_clear(cfg_clear), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_bit(input int side, input int i);
    case (side)
      0: return in_n[i];
      1: return in_e[i];
      2: return in_s[i];
      default: return in_w[i];
    endcase
  endfunction

  function automatic logic mux_val(input int o);
    int sel;
    sel = int'(m_active[3*o +: 2]);
    if (sel == 0) return 1'b0;
    return in_bit(((o / W) + sel) % 4, o % W);
  endfunction

  function automatic logic [NO-1:0] exp_out();
    logic [NO-1:0] v;
    for (int o = 0; o < NO; o++) v[o] = m_active[3*o+2] ? m_q[o] : mux_val(o);
    return v;
  endfunction

  task automatic check_all();
    chk("outs",  {out_w, out_s, out_e, out_n}, exp_out());
    chk("ready", cfg_ready, !m_err && !m_pend);
    chk("err",   cfg_err, m_err);
    chk("busy",  cfg_busy, m_err || m_pend || (m_n > 0));
    chk("done",  cfg_done, m_pend);
  endtask

  task automatic rand_inputs();
    {in_n, in_e, in_s, in_w} = NO'($urandom);
  endtask

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_q = '0;
    m_err = 0; m_pend = 0; m_n = 0;
  endtask

  // one clock: model advances from pre-edge inputs, then outputs are compared
  task automatic tick();
    logic [NO-1:0] qn;
    bit acc, lst, clr;
    logic [CW-1:0] dat;
    int n;
    for (int o = 0; o < NO; o++) qn[o] = mux_val(o);
    acc = cfg_valid && !m_err && !m_pend;
    lst = cfg_last; clr = cfg_clear; dat = cfg_data;
    @(posedge clk); #1;
    m_q = qn;
    if (m_pend) begin
      m_active = m_shadow; m_pend = 0; m_n = 0;
    end else if (m_err) begin
      if (clr) begin m_err = 0; m_n = 0; end
    end else if (acc) begin
      for (int j = 0; j < CW; j++)
        if (m_n*CW + j < NBITS) m_shadow[m_n*CW + j] = dat[j];
      n = m_n + 1;
      if (lst) begin
        if (n == NWORDS) m_pend = 1; else m_err = 1;
        m_n = 0;
      end else if (n == NWORDS) begin
        m_err = 1; m_n = 0;
      end else m_n = n;
    end
    if (rnd_in) rand_inputs();
    #1;
    check_all();
  endtask

  // send n words of c; last_at is the 1-based word carrying cfg_last (0 = none)
  task automatic send(input logic [NBITS-1:0] c, input int n, input int last_at, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int x = 0; x < g; x++) begin
          cfg_valid = 0; cfg_clear = 1'($urandom); tick();
        end
      end
      cfg_valid = 1;
      cfg_data  = c[k*CW +: CW];
      cfg_last  = (k + 1 == last_at);
      cfg_clear = 1'($urandom);
      tick();
    end
    cfg_valid = 0; cfg_last = 0; cfg_clear = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    model_reset();
    check_all();
    rand_inputs(); #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst = 0; #1;
    check_all();
  endtask

  function automatic logic [NBITS-1:0] rand_cfg();
    return NBITS'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic [NBITS-1:0] c;
    model_reset();

    // reset state with random inputs
    do_reset();

    // out_n[0] from south track 0, combinational
    c = '0; c[2:0] = 3'b010;
    send(c, NWORDS, NWORDS, 0);
    chk("done_after_last", cfg_done, 1'b1);
    tick();
    rnd_in = 0;
    {in_n, in_e, in_s, in_w} = '0; in_s[0] = 1'b1; #1;
    chk("n0_route", {out_w, out_s, out_e, out_n}, 64'h1);
    in_s = '1; in_e = '1; in_w = '1; in_n = '1; #1;
    chk("n0_only", {out_w, out_s, out_e, out_n}, 64'h1);

    // out_e[3] registered from west track 3
    c = '0; c[3*(W+3) +: 3] = 3'b110;
    {in_n, in_e, in_s, in_w} = '0;
    send(c, NWORDS, NWORDS, 0);
    tick(); tick();
    chk("e3_low", out_e[3], 1'b0);
    in_w[3] = 1'b1; #1;
    chk("e3_not_yet", out_e[3], 1'b0);
    tick();
    chk("e3_rise", out_e[3], 1'b1);
    rnd_in = 1;

    // early last on word 5, held valid in ERROR, clear, reload
    send(rand_cfg(), 5, 5, 1);
    chk("err5", cfg_err, 1'b1);
    cfg_valid = 1; cfg_data = CW'($urandom);
    tick(); tick();
    cfg_valid = 0; cfg_clear = 1;
    tick();
    cfg_clear = 0;
    chk("cleared", cfg_busy, 1'b0);
    send(rand_cfg(), NWORDS, NWORDS, 1);
    tick(); tick();

    // final word without last -> error; then valid held through COMMIT
    send(rand_cfg(), NWORDS, 0, 0);
    chk("err_nolast", cfg_err, 1'b1);
    cfg_clear = 1; tick(); cfg_clear = 0;
    send(rand_cfg(), NWORDS, NWORDS, 0);
    cfg_valid = 1; cfg_data = CW'($urandom); cfg_last = 1;
    tick();
    cfg_valid = 0; cfg_last = 0;
    tick(); tick();

    // reset in the middle of a reload, then fresh load
    send(rand_cfg(), NWORDS, NWORDS, 0);
    tick(); tick();
    send(rand_cfg(), 6, 0, 1);
    do_reset();
    send(rand_cfg(), NWORDS, NWORDS, 1);
    tick(); tick();

    // reset while in ERROR
    send(rand_cfg(), 3, 3, 0);
    do_reset();
    send(rand_cfg(), NWORDS, NWORDS, 0);
    tick(); tick();

    // random streams of all kinds
    for (int s = 0; s < 30; s++) begin
      int mode, n;
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1: send(rand_cfg(), NWORDS, NWORDS, 1);
        2: begin n = $urandom_range(1, NWORDS - 1); send(rand_cfg(), n, n, 1); end
        default: send(rand_cfg(), NWORDS, 0, 1);
      endcase
      for (int x = 0; x < 3; x++) begin
        cfg_valid = 1'($urandom); cfg_data = CW'($urandom);
        cfg_last = 1'($urandom); cfg_clear = 1'($urandom);
        if (!m_err && !m_pend) cfg_valid = 0;
        tick();
      end
      cfg_valid = 0; cfg_last = 0; cfg_clear = 1;
      tick();
      cfg_clear = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
